// File: rtl/apb_gpio_deb.sv
// apb_gpio_deb: APB GPIO controller with per-pin two-flop synchroniser, shared-prescaler
// debouncer, per-pin interrupt mode (fall / rise / both / level-high) and W1C status.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   PADDR .. PSLVERR       APB slave (zero wait states, PREADY tied high)
//   gpio_in_i              raw asynchronous pad inputs
//   gpio_out_o, gpio_oe_o  registered pad output value / output enable
//   gpio_in_sync_o         debounced input value
//   interrupt_o            registered OR of INTSTAT & INTEN
module apb_gpio_deb #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned PAD_NUM        = 32,
    parameter int unsigned DB_SAMPLES     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [PAD_NUM-1:0]        gpio_in_i,
    output logic [PAD_NUM-1:0]        gpio_out_o,
    output logic [PAD_NUM-1:0]        gpio_oe_o,
    output logic [PAD_NUM-1:0]        gpio_in_sync_o,
    output logic                      interrupt_o
);

    localparam logic [3:0] CntMax = 4'(DB_SAMPLES - 1);

    logic [PAD_NUM-1:0] dir_q, out_q, inten_q, inttyp0_q, inttyp1_q, intstat_q;
    logic [PAD_NUM-1:0] intstat_d, event_w, w1c_mask;
    logic [15:0]        period_q, presc_q;
    logic               db_en_q;
    logic [PAD_NUM-1:0] sync1_q, sync2_q, db_q, db_d, prev_q;
    logic [PAD_NUM-1:0][3:0] cnt_q, cnt_d;
    logic [PAD_NUM-1:0] gpio_out_q, gpio_oe_q;
    logic               irq_q;

    logic [3:0]         reg_addr;
    logic               unmapped, wr_en, wr_ok, cfg_wr, tick;
    logic [PAD_NUM-1:0] wdata;
    logic               unused_bits;

    assign reg_addr    = PADDR[5:2];
    assign unmapped    = reg_addr[3];
    assign wr_en       = PSEL & PENABLE & PWRITE;
    assign wr_ok       = wr_en & ~unmapped & (reg_addr != 4'd2);
    assign wdata       = PWDATA[PAD_NUM-1:0];
    assign cfg_wr      = wr_ok & (reg_addr == 4'd7);
    assign tick        = db_en_q & (presc_q == period_q);
    assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0], PWDATA[31:17]};

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & (unmapped | (PWRITE & (reg_addr == 4'd2)));

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (reg_addr)
                4'd0: PRDATA[PAD_NUM-1:0] = dir_q;
                4'd1: PRDATA[PAD_NUM-1:0] = out_q;
                4'd2: PRDATA[PAD_NUM-1:0] = db_q;
                4'd3: PRDATA[PAD_NUM-1:0] = inten_q;
                4'd4: PRDATA[PAD_NUM-1:0] = inttyp0_q;
                4'd5: PRDATA[PAD_NUM-1:0] = inttyp1_q;
                4'd6: PRDATA[PAD_NUM-1:0] = intstat_q;
                4'd7: PRDATA[16:0]        = {db_en_q, period_q};
                default: PRDATA = '0;
            endcase
        end
    end

    // Edge/level events come from the debounced value against its one-cycle-old copy.
    always_comb begin
        for (int i = 0; i < int'(PAD_NUM); i++) begin
            case ({inttyp1_q[i], inttyp0_q[i]})
                2'b00:   event_w[i] = ~db_q[i] & prev_q[i];
                2'b01:   event_w[i] = db_q[i] & ~prev_q[i];
                2'b10:   event_w[i] = db_q[i] ^ prev_q[i];
                default: event_w[i] = db_q[i];
            endcase
        end
    end

    // A set in the same cycle as a W1C clear wins.
    assign w1c_mask  = (wr_ok && reg_addr == 4'd6) ? wdata : '0;
    assign intstat_d = (intstat_q & ~w1c_mask) | event_w;

    // Debounce: a pin accepts the new level on the DB_SAMPLES-th consecutive differing tick.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int i = 0; i < int'(PAD_NUM); i++) begin
            if (!db_en_q) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else if (cfg_wr) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == CntMax) begin
                        db_d[i]  = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q      <= '0;
            out_q      <= '0;
            inten_q    <= '0;
            inttyp0_q  <= '0;
            inttyp1_q  <= '0;
            intstat_q  <= '0;
            period_q   <= '0;
            db_en_q    <= 1'b0;
            presc_q    <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            prev_q     <= '0;
            cnt_q      <= '0;
            gpio_out_q <= '0;
            gpio_oe_q  <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_ok) begin
                case (reg_addr)
                    4'd0: dir_q     <= wdata;
                    4'd1: out_q     <= wdata;
                    4'd3: inten_q   <= wdata;
                    4'd4: inttyp0_q <= wdata;
                    4'd5: inttyp1_q <= wdata;
                    4'd7: begin
                        period_q <= PWDATA[15:0];
                        db_en_q  <= PWDATA[16];
                    end
                    default: ;
                endcase
            end
            if (cfg_wr || !db_en_q || tick) begin
                presc_q <= '0;
            end else begin
                presc_q <= presc_q + 16'd1;
            end
            intstat_q  <= intstat_d;
            sync1_q    <= gpio_in_i;
            sync2_q    <= sync1_q;
            db_q       <= db_d;
            prev_q     <= db_q;
            cnt_q      <= cnt_d;
            gpio_out_q <= out_q;
            gpio_oe_q  <= dir_q;
            irq_q      <= |(intstat_q & inten_q);
        end
    end

    assign gpio_out_o     = gpio_out_q;
    assign gpio_oe_o      = gpio_oe_q;
    assign gpio_in_sync_o = db_q;
    assign interrupt_o    = irq_q;

endmodule

// File: tb/tb_apb_gpio_deb.sv
module tb_apb_gpio_deb;

    localparam int unsigned PN  = 32;
    localparam int          DBS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out, gpio_oe, gpio_in_sync;
    logic        interrupt;

    always #5 clk = ~clk;

    apb_gpio_deb #(.APB_ADDR_WIDTH(12), .PAD_NUM(PN), .DB_SAMPLES(DBS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .gpio_in_i(gpio_in), .gpio_out_o(gpio_out), .gpio_oe_o(gpio_oe),
        .gpio_in_sync_o(gpio_in_sync), .interrupt_o(interrupt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register file plus a cycle-level view of the input path.
    logic [31:0] m_dir, m_out, m_inten, m_t0, m_t1, m_stat, m_gout, m_goe;
    logic [31:0] m_sync1, m_sync2, m_db, m_prev;
    logic [15:0] m_period;
    logic        m_en, m_irq;
    int          m_run[32];
    int          m_since;

    task automatic model_reset();
        {m_dir, m_out, m_inten, m_t0, m_t1, m_stat, m_gout, m_goe} = '0;
        {m_sync1, m_sync2, m_db, m_prev} = '0;
        m_period = '0;
        m_en = 1'b0;
        m_irq = 1'b0;
        m_since = 0;
        foreach (m_run[i]) m_run[i] = 0;
    endtask

    function automatic logic m_err(input logic [3:0] a, input logic wr);
        return (a > 4'd7) || (wr && a == 4'd2);
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'd0: return m_dir;
            4'd1: return m_out;
            4'd2: return m_db;
            4'd3: return m_inten;
            4'd4: return m_t0;
            4'd5: return m_t1;
            4'd6: return m_stat;
            4'd7: return {15'd0, m_en, m_period};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0]  a;
        logic        wr, tk;
        logic [31:0] ev, clr, nstat, ndb;
        a  = PADDR[5:2];
        wr = PSEL && PENABLE && PWRITE && !m_err(a, 1'b1);
        for (int i = 0; i < 32; i++) begin
            case ({m_t1[i], m_t0[i]})
                2'b00: ev[i] = (m_prev[i] == 1'b1) && (m_db[i] == 1'b0);
                2'b01: ev[i] = (m_prev[i] == 1'b0) && (m_db[i] == 1'b1);
                2'b10: ev[i] = (m_prev[i] != m_db[i]);
                default: ev[i] = (m_db[i] == 1'b1);
            endcase
        end
        clr   = (wr && a == 4'd6) ? PWDATA : 32'd0;
        nstat = (m_stat & ~clr) | ev;
        ndb   = m_db;
        if (!m_en) begin
            ndb = m_sync2;
            foreach (m_run[i]) m_run[i] = 0;
            m_since = 0;
        end else if (wr && a == 4'd7) begin
            foreach (m_run[i]) m_run[i] = 0;
            m_since = 0;
        end else begin
            tk = (m_since % (int'(m_period) + 1)) == int'(m_period);
            m_since++;
            if (tk) begin
                for (int i = 0; i < 32; i++) begin
                    if (m_sync2[i] != m_db[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DBS) begin
                            ndb[i] = m_sync2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
        end
        m_gout  = m_out;
        m_goe   = m_dir;
        m_irq   = (m_stat & m_inten) != 0;
        m_prev  = m_db;
        m_db    = ndb;
        m_stat  = nstat;
        m_sync2 = m_sync1;
        m_sync1 = gpio_in;
        if (wr) begin
            case (a)
                4'd0: m_dir = PWDATA;
                4'd1: m_out = PWDATA;
                4'd3: m_inten = PWDATA;
                4'd4: m_t0 = PWDATA;
                4'd5: m_t1 = PWDATA;
                4'd7: begin
                    m_period = PWDATA[15:0];
                    m_en = PWDATA[16];
                end
                default: ;
            endcase
        end
    endtask

    // One clock: advance the model on the edge, compare outputs on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check("in_sync", gpio_in_sync, m_db);
        check("gpio_out", gpio_out, m_gout);
        check("gpio_oe", gpio_oe, m_goe);
        check("irq", interrupt, m_irq);
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        cyc();
        PENABLE = 1'b1;
        #1 check("pslverr_wr", PSLVERR, m_err(addr[5:2], 1'b1));
        cyc();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1;
        check("prdata", PRDATA, m_read(addr[5:2]));
        check("pslverr_rd", PSLVERR, m_err(addr[5:2], 1'b0));
        data = PRDATA;
        cyc();
        PENABLE = 1'b1;
        cyc();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen;
        int          k;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;

        // Reset state of every offset, then an unmapped read.
        for (int i = 0; i < 8; i++) begin
            apb_read(12'(i * 4), rd);
            check("reset_reg", rd, 32'd0);
        end
        apb_read(12'h020, rd);
        check("unmapped_rd", rd, 32'd0);
        check("pready", PREADY, 1'b1);

        apb_write(12'h000, 32'h0000_F0F0);
        apb_write(12'h004, 32'h0000_A5A5);
        cyc();
        check("oe_value", gpio_oe, 32'h0000_F0F0);
        check("out_value", gpio_out, 32'h0000_A5A5);
        apb_write(12'h008, 32'hFFFF_FFFF);
        apb_read(12'h008, rd);
        check("in_ro", rd, 32'd0);

        // Debounce off: three cycles of input latency.
        gpio_in[3] = 1'b1;
        cyc(); cyc();
        check("lat_2", gpio_in_sync[3], 1'b0);
        cyc();
        check("lat_3", gpio_in_sync[3], 1'b1);

        // Debounce on, PERIOD = 9: a 25-cycle glitch is dropped, a long level is taken.
        apb_write(12'h01C, 32'h0001_0009);
        seen = 1'b0;
        gpio_in[0] = 1'b1;
        repeat (25) begin cyc(); seen |= gpio_in_sync[0]; end
        gpio_in[0] = 1'b0;
        repeat (50) begin cyc(); seen |= gpio_in_sync[0]; end
        check("glitch_blocked", seen, 1'b0);
        gpio_in[0] = 1'b1;
        k = 0;
        while (gpio_in_sync[0] !== 1'b1 && k < 43) begin cyc(); k++; end
        check("level_taken", gpio_in_sync[0], 1'b1);
        repeat (60 - k) cyc();
        gpio_in[0] = 1'b0;
        repeat (50) cyc();

        // Interrupt modes: pin1 rise, pin2 both, pin5 rise, pin6 level-high.
        apb_write(12'h01C, 32'h0000_0000);
        apb_write(12'h010, 32'h0000_0062);
        apb_write(12'h014, 32'h0000_0044);
        apb_write(12'h018, 32'hFFFF_FFFF);
        gpio_in[1] = 1'b1;
        repeat (5) cyc();
        apb_read(12'h018, rd);
        check("stat1_set", rd[1], 1'b1);
        check("irq_masked", interrupt, 1'b0);
        apb_write(12'h00C, 32'h0000_0002);
        cyc();
        check("irq_on", interrupt, 1'b1);
        apb_write(12'h018, 32'h0000_0002);
        cyc();
        check("irq_off", interrupt, 1'b0);

        gpio_in[2] = 1'b1;
        repeat (5) cyc();
        apb_read(12'h018, rd);
        check("stat2_first", rd[2], 1'b1);
        apb_write(12'h018, 32'h0000_0004);
        apb_read(12'h018, rd);
        check("stat2_clr", rd[2], 1'b0);
        gpio_in[2] = 1'b0;
        repeat (5) cyc();
        apb_read(12'h018, rd);
        check("stat2_second", rd[2], 1'b1);

        // Pin5 edge lands on the same clock as the W1C write edge.
        gpio_in[5] = 1'b1;
        cyc(); cyc();
        apb_write(12'h018, 32'h0000_0020);
        apb_read(12'h018, rd);
        check("set_wins", rd[5], 1'b1);

        gpio_in[6] = 1'b1;
        repeat (5) cyc();
        apb_write(12'h018, 32'h0000_0040);
        apb_read(12'h018, rd);
        check("level_hold", rd[6], 1'b1);
        gpio_in[6] = 1'b0;
        repeat (5) cyc();
        apb_write(12'h018, 32'h0000_0040);
        apb_read(12'h018, rd);
        check("level_clr", rd[6], 1'b0);

        // Asynchronous reset in the middle of operation.
        apb_write(12'h00C, 32'hFFFF_FFFF);
        repeat (3) cyc();
        #2 rst_n = 1'b0;
        #1;
        check("arst_out", gpio_out, 32'd0);
        check("arst_oe", gpio_oe, 32'd0);
        check("arst_irq", interrupt, 1'b0);
        check("arst_in", gpio_in_sync, 32'd0);
        model_reset();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Random traffic against the model.
        for (int it = 0; it < 1500; it++) begin
            int r;
            logic [11:0] a;
            r = $urandom_range(0, 9);
            if (r <= 2) begin
                gpio_in[$urandom_range(0, 7)] ^= 1'b1;
                cyc();
            end else if (r == 3) begin
                a = 12'($urandom_range(0, 8) * 4);
                if (a == 12'h01C)
                    apb_write(a, {15'd0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3))});
                else
                    apb_write(a, $urandom);
            end else if (r == 4) begin
                apb_read(12'($urandom_range(0, 8) * 4), rd);
            end else begin
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_gpio_deb.md
Name: apb_gpio_deb

Overview:
Next-generation APB GPIO controller for the IO subsystem.
- Pin count is parametrised.
- Each input has a two-flop synchroniser followed by a programmable debouncer.
- Each pin has its own interrupt mode: rising, falling, both edges or level-high.
- Interrupt status bits are write-1-to-clear, and all pin status is ORed into one interrupt line.
- It sits beside the uDMA subsystem in the IO wrapper, on its own APB slave port, and drives pad output/enable directly.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; only bits [5:2] are decoded.
PAD_NUM, 32, number of GPIO pins, legal range 1..32.
DB_SAMPLES, 4, consecutive equal debounce ticks needed to accept a new level, legal range 2..15.

Ports:
clk_i  in  1  single clock for the whole block.
rst_ni  in  1  reset, asynchronous, active-low.
PADDR  in  APB_ADDR_WIDTH  APB address.
PWDATA  in  32  APB write data.
PWRITE  in  1  APB write.
PSEL  in  1  APB select.
PENABLE  in  1  APB enable.
PRDATA  out  32  APB read data.
PREADY  out  1  always 1.
PSLVERR  out  1  error response.
gpio_in_i  in  PAD_NUM  raw pad inputs, asynchronous.
gpio_out_o  out  PAD_NUM  pad output values.
gpio_oe_o  out  PAD_NUM  pad output enables (1 = drive).
gpio_in_sync_o  out  PAD_NUM  debounced input value.
interrupt_o  out  1  registered OR of (INTSTAT & INTEN).

Behaviour:
- Reset values: all registers 0, all outputs 0, debounce counters 0, prescaler 0.
- Register map, word offsets:
  - 0x00 DIR RW (1 = output).
  - 0x04 OUT RW.
  - 0x08 IN RO (debounced value).
  - 0x0C INTEN RW.
  - 0x10 INTTYP0 RW.
  - 0x14 INTTYP1 RW.
  - 0x18 INTSTAT RW1C.
  - 0x1C DBCFG RW: [15:0] PERIOD, [16] EN.
- Register widths: bits at or above PAD_NUM read 0 and ignore writes.
- APB access:
  - Access completes in the enable phase with zero wait states; register updates on the clk_i edge where PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR during PSEL.
  - PSLVERR = 1 for an unmapped offset (>0x1C) or a write to IN; such writes change nothing and unmapped reads return 0.
- Outputs: gpio_out_o = OUT and gpio_oe_o = DIR, both registered; they change one cycle after the write edge.
- Synchroniser: two flops per pin. sync = raw delayed by 2 cycles.
- Debounce:
  - DBCFG.EN = 0: the debounced value takes sync each cycle (1 extra flop, total input latency 3 cycles).
  - DBCFG.EN = 1: a shared 16-bit prescaler counts 0..PERIOD. A tick is issued when it equals PERIOD, then it wraps to 0. PERIOD = 0 gives a tick every cycle.
  - On each tick, per pin: if sync != debounced, cnt++; otherwise cnt = 0.
  - When cnt reaches DB_SAMPLES-1 and sync still differs: debounced <= sync, cnt <= 0.
  - A glitch shorter than DB_SAMPLES ticks never propagates.
  - Any write to DBCFG clears the prescaler and all cnt. The debounced value is kept.
- Edge detect: a per-pin previous-value flop tracks the debounced value. Mode = {INTTYP1[i], INTTYP0[i]}:
  - 00 falling edge.
  - 01 rising edge.
  - 10 either edge.
  - 11 level high (sets every cycle while debounced = 1).
- INTSTAT:
  - Bit i sets on an event regardless of INTEN; INTEN masks only interrupt_o.
  - Writing 1 clears the bit.
  - If a set and a W1C clear of the same bit fall in the same cycle, the set wins.
- interrupt_o: registered. It asserts the cycle after INTSTAT&INTEN becomes non-zero and deasserts the cycle after it becomes zero.
- Reset mid-operation: asynchronous clear of every flop. There is no pending-interrupt memory across reset.

Test Plan:
- Reset then read all 8 offsets -> all return 0, PSLVERR = 0; read 0x20 -> PRDATA 0, PSLVERR = 1.
- Write DIR = 0xF0F0, OUT = 0xA5A5 -> gpio_oe_o = 0xF0F0 and gpio_out_o = 0xA5A5 one cycle after each write edge; write IN -> PSLVERR = 1 and IN unchanged.
- Debounce off, drive pin 3 0->1 -> IN[3] = 1 exactly 3 cycles later.
- DBCFG = {EN = 1, PERIOD = 9}, DB_SAMPLES = 4:
  - 25-cycle pulse on pin 0 -> IN[0] never changes.
  - 60-cycle level on pin 0 -> IN[0] = 1 within 3 + 40 cycles.
- Edge modes:
  - Pin 1 rising with INTEN = 0 -> INTSTAT[1] = 1 and interrupt_o = 0; set INTEN[1] -> interrupt_o = 1 next cycle; W1C 0x2 -> interrupt_o = 0 next cycle.
  - Pin 2 mode 10 with two toggles -> INTSTAT[2] set by each toggle.
- Same-cycle conflict: W1C of bit 5 coincides with a pin 5 edge -> INTSTAT[5] stays 1.
- Level mode 11 with the pin held high -> W1C is ineffective while high; the bit clears only after the pin falls.
